// File: rtl/key_pkg.sv
// Shared types and parameter derivations for the key debouncer.
// Counter widths are computed here so the top level and the per-key logic agree.
package key_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPressWait,
    StPressed,
    StLongHeld,
    StReleaseWait
  } key_state_e;

  // Number of clk cycles per 1 ms tick.
  function automatic int unsigned tick_div(input int unsigned freq_hz);
    return freq_hz / 1000;
  endfunction

  // Bits needed to hold 0..max_val inclusive; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// Per-key debouncer: 2-flop synchronizer, press/release FSM, stability and long-press counters.
// All outputs are registered and change on the same edge as the accepted state transition.
module key_debounce_fsm
  import key_pkg::*;
#(
  parameter int unsigned DebounceMs = 20,
  parameter int unsigned LongMs     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic key_raw_i,
  output logic user_key_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned StabW = cnt_width(DebounceMs);
  localparam int unsigned LongW = cnt_width(LongMs);
  localparam logic [StabW-1:0] StabMax = StabW'(DebounceMs);
  localparam logic [LongW-1:0] LongMax = LongW'(LongMs);

  logic [1:0]       sync_q;
  logic             key;
  key_state_e       state_q, state_d;
  logic [StabW-1:0] stab_q, stab_d;
  logic [LongW-1:0] long_cnt_q, long_cnt_d;
  logic             was_long_q, was_long_d;
  logic             user_key_q, user_key_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_raw_i};
    end
  end

  assign key = sync_q[1];

  // A transition fires on the tick after the counter already holds its limit, so the key must
  // be stable for between Max and Max+1 full tick periods.
  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    long_cnt_d = long_cnt_q;
    was_long_d = was_long_q;
    user_key_d = user_key_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!key) begin
          state_d = StPressWait;
          stab_d  = '0;
        end
      end
      StPressWait: begin
        if (key) begin
          state_d = StIdle;
        end else if (tick_i) begin
          if (stab_q == StabMax) begin
            state_d    = StPressed;
            user_key_d = 1'b0;
            press_d    = 1'b1;
            long_cnt_d = '0;
            was_long_d = 1'b0;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
      end
      StPressed: begin
        if (key) begin
          state_d = StReleaseWait;
          stab_d  = '0;
        end else if (tick_i) begin
          if (long_cnt_q == LongMax) begin
            state_d    = StLongHeld;
            long_d     = 1'b1;
            was_long_d = 1'b1;
          end else begin
            long_cnt_d = long_cnt_q + 1'b1;
          end
        end
      end
      StLongHeld: begin
        if (key) begin
          state_d = StReleaseWait;
          stab_d  = '0;
        end
      end
      StReleaseWait: begin
        // A short high glitch returns to the held state with the long count untouched.
        if (!key) begin
          state_d = was_long_q ? StLongHeld : StPressed;
        end else if (tick_i) begin
          if (stab_q == StabMax) begin
            state_d    = StIdle;
            user_key_d = 1'b1;
            release_d  = 1'b1;
            long_cnt_d = '0;
            was_long_d = 1'b0;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      stab_q     <= '0;
      long_cnt_q <= '0;
      was_long_q <= 1'b0;
      user_key_q <= 1'b1;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_q     <= stab_d;
      long_cnt_q <= long_cnt_d;
      was_long_q <= was_long_d;
      user_key_q <= user_key_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign user_key_o = user_key_q;
  assign press_o    = press_q;
  assign release_o  = release_q;
  assign long_o     = long_q;

  assert property (@(posedge clk) disable iff (rst) !(press_q && release_q));
  assert property (@(posedge clk) disable iff (rst) long_q |-> !user_key_q);

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: one shared 1 ms tick prescaler feeding KEYS independent per-key FSMs.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned frequency   = 27_000_000,
  parameter int unsigned KEYS        = 4,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KEYS-1:0] key_raw_i,
  output logic [KEYS-1:0] user_key_o,
  output logic [KEYS-1:0] press_o,
  output logic [KEYS-1:0] release_o,
  output logic [KEYS-1:0] long_o
);

  localparam int unsigned TickDiv = tick_div(frequency);
  localparam int unsigned TickW   = cnt_width(TickDiv - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);

  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  always_comb begin
    tick       = (tick_cnt_q == TickLast);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar k = 0; k < KEYS; k++) begin : g_key
    key_debounce_fsm #(
      .DebounceMs(DEBOUNCE_MS),
      .LongMs    (LONG_MS)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick),
      .key_raw_i (key_raw_i[k]),
      .user_key_o(user_key_o[k]),
      .press_o   (press_o[k]),
      .release_o (release_o[k]),
      .long_o    (long_o[k])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce at 10 kHz (1 ms tick = 10 cycles), 4 ms debounce, 20 ms long.
module tb_key_debounce;

  localparam int unsigned Freq   = 10_000;
  localparam int unsigned Keys   = 4;
  localparam int unsigned DebMs  = 4;
  localparam int unsigned LongMs = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_raw;
  logic [3:0] user_key;
  logic [3:0] press;
  logic [3:0] rel_o;
  logic [3:0] long_v;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned press_cnt [4];
  int unsigned rel_cnt   [4];
  int unsigned long_cnt  [4];
  int unsigned press_cyc [4];
  int unsigned long_cyc  [4];
  int unsigned both_press = 0;
  int unsigned both_rel   = 0;
  int unsigned excl_viol  = 0;
  int unsigned long_viol  = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .frequency  (Freq),
    .KEYS       (Keys),
    .DEBOUNCE_MS(DebMs),
    .LONG_MS    (LongMs)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw_i (key_raw),
    .user_key_o(user_key),
    .press_o   (press),
    .release_o (rel_o),
    .long_o    (long_v)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Event monitor sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (press[k] === 1'b1) begin
        press_cnt[k]++;
        press_cyc[k] = cyc;
      end
      if (rel_o[k] === 1'b1) rel_cnt[k]++;
      if (long_v[k] === 1'b1) begin
        long_cnt[k]++;
        long_cyc[k] = cyc;
      end
      if (press[k] === 1'b1 && rel_o[k] === 1'b1) excl_viol++;
      if (long_v[k] === 1'b1 && user_key[k] !== 1'b0) long_viol++;
    end
    if (press === 4'b1001) both_press++;
    if (rel_o === 4'b1001) both_rel++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    int          lat;
    int unsigned r3;
    int unsigned p3;

    rst     = 1'b1;
    key_raw = 4'hF;
    wait_cycles(3);
    check("rst_user_key", 32'(user_key), 32'hF);
    check("rst_press", 32'(press), 0);
    check("rst_release", 32'(rel_o), 0);
    check("rst_long", 32'(long_v), 0);
    rst = 1'b0;

    // Idle keys: nothing happens.
    wait_cycles(100);
    check("idle_user_key", 32'(user_key), 32'hF);
    check("idle_no_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    check("idle_no_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);

    // Key 0 bounces, then settles low.
    for (int b = 0; b < 3; b++) begin
      key_raw[0] = 1'b0;
      wait_cycles(5);
      key_raw[0] = 1'b1;
      wait_cycles(5);
    end
    check("k0_bounce_no_press", press_cnt[0], 0);
    key_raw[0] = 1'b0;
    t0 = cyc;
    wait_cycles(70);
    check("k0_press_once", press_cnt[0], 1);
    lat = int'(press_cyc[0]) - int'(t0) - 1;
    check($sformatf("k0_press_lat=%0d_in_42..52", lat), 32'(lat >= 42 && lat <= 52), 1);
    check("k0_user_key_low", 32'(user_key[0]), 0);
    key_raw[0] = 1'b1;
    wait_cycles(70);
    check("k0_release_once", rel_cnt[0], 1);
    check("k0_user_key_high", 32'(user_key[0]), 1);
    check("k0_no_long", long_cnt[0], 0);

    // Key 2 held long: one press, one long, no repeat.
    key_raw[2] = 1'b0;
    wait_cycles(400);
    check("k2_press_once", press_cnt[2], 1);
    check("k2_long_once", long_cnt[2], 1);
    lat = int'(long_cyc[2]) - int'(press_cyc[2]);
    check($sformatf("k2_long_delay=%0d_in_195..215", lat), 32'(lat >= 195 && lat <= 215), 1);
    check("k2_user_key_low", 32'(user_key[2]), 0);
    key_raw[2] = 1'b1;
    wait_cycles(70);
    check("k2_release_once", rel_cnt[2], 1);

    // Key 1 held with a 15-cycle high glitch: long count pauses then resumes.
    key_raw[1] = 1'b0;
    wait_cycles(80);
    key_raw[1] = 1'b1;
    wait_cycles(15);
    key_raw[1] = 1'b0;
    wait_cycles(300);
    check("k1_glitch_no_release", rel_cnt[1], 0);
    check("k1_press_once", press_cnt[1], 1);
    check("k1_long_once", long_cnt[1], 1);
    lat = int'(long_cyc[1]) - int'(press_cyc[1]);
    check($sformatf("k1_long_delay=%0d_in_205..235", lat), 32'(lat >= 205 && lat <= 235), 1);
    key_raw[1] = 1'b1;
    wait_cycles(70);
    check("k1_release_once", rel_cnt[1], 1);

    // Keys 0 and 3 together.
    key_raw = 4'b0110;
    wait_cycles(70);
    check("k03_press_same_cycle", both_press, 1);
    check("k03_user_key", 32'(user_key), 32'b0110);
    key_raw = 4'hF;
    wait_cycles(70);
    check("k03_release_same_cycle", both_rel, 1);
    check("k03_user_key_rel", 32'(user_key), 32'hF);

    // Key 3 in long-held, then reset while still held.
    key_raw[3] = 1'b0;
    wait_cycles(280);
    check("k3_long_before_rst", long_cnt[3], 1);
    r3  = rel_cnt[3];
    rst = 1'b1;
    wait_cycles(2);
    check("rst_mid_user_key", 32'(user_key), 32'hF);
    check("rst_mid_press", 32'(press), 0);
    rst = 1'b0;
    t0  = cyc;
    p3  = press_cnt[3];
    wait_cycles(70);
    check("rst_mid_no_release", rel_cnt[3], r3);
    check("k3_repress_once", press_cnt[3], p3 + 1);
    lat = int'(press_cyc[3]) - int'(t0) - 1;
    check($sformatf("k3_repress_lat=%0d_in_42..52", lat), 32'(lat >= 42 && lat <= 52), 1);
    check("k3_user_key_low", 32'(user_key[3]), 0);
    key_raw = 4'hF;
    wait_cycles(70);

    check("press_release_exclusive", excl_viol, 0);
    check("long_only_when_low", long_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
